// File: rtl/mips_cpu_sequencer_if.sv
// rtl/mips_cpu_sequencer_if.sv - datapath status in, sequencer state and control out
interface mips_cpu_sequencer_if #(
  parameter int COUNT_W = 32
);
  logic [2:0]         exec_cycles;
  logic               mem_access;
  logic               waitrequest;
  logic               muldiv_wait;
  logic               muldiv_busy;
  logic               branch_taken;
  logic               target_zero;
  logic [2:0]         state;
  logic               exec_last;
  logic               stall;
  logic               active;
  logic               pc_use_target;
  logic               in_delay_slot;
  logic               retire;
  logic [COUNT_W-1:0] instr_count;

  modport master (
    output exec_cycles, mem_access, waitrequest, muldiv_wait, muldiv_busy,
           branch_taken, target_zero,
    input  state, exec_last, stall, active, pc_use_target, in_delay_slot,
           retire, instr_count
  );

  modport slave (
    input  exec_cycles, mem_access, waitrequest, muldiv_wait, muldiv_busy,
           branch_taken, target_zero,
    output state, exec_last, stall, active, pc_use_target, in_delay_slot,
           retire, instr_count
  );
endinterface

// File: rtl/mips_cpu_sequencer.sv
// rtl/mips_cpu_sequencer.sv - multicycle FETCH/DECODE/EXECn sequencer with stalls,
// delay-slot tracking and halt on a taken jump to address 0
module mips_cpu_sequencer #(
  parameter int EXEC_STATES = 3,
  parameter int COUNT_W     = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  mips_cpu_sequencer_if.slave   bus
);
  typedef enum logic [2:0] {
    ST_HALTED = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC1  = 3'd3,
    ST_EXEC2  = 3'd4,
    ST_EXEC3  = 3'd5,
    ST_EXEC4  = 3'd6,
    ST_EXEC5  = 3'd7
  } state_t;

  localparam logic [2:0] MAX_EXEC = 3'(EXEC_STATES);

  state_t             state_q, state_d;
  logic [2:0]         cnt_q;
  logic               redirect_q;
  logic               halt_pend_q;
  logic               delay_q;
  logic [COUNT_W-1:0] count_q;

  logic               in_exec;
  logic [2:0]         exec_idx;
  logic               is_last;
  logic               stall_c;
  logic               retire_c;
  logic [2:0]         ec_clamped;

  always_comb begin
    in_exec    = (state_q >= ST_EXEC1);
    exec_idx   = 3'(state_q) - 3'd2;
    is_last    = in_exec && (exec_idx == cnt_q);
    stall_c    = ((state_q == ST_FETCH) && bus.waitrequest) ||
                 (in_exec && ((bus.mem_access && bus.waitrequest) ||
                              (bus.muldiv_wait && bus.muldiv_busy)));
    retire_c   = is_last && !stall_c;
    ec_clamped = bus.exec_cycles;
    if (bus.exec_cycles == 3'd0)
      ec_clamped = 3'd1;
    else if (bus.exec_cycles > MAX_EXEC)
      ec_clamped = MAX_EXEC;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_HALTED: state_d = ST_HALTED;
      ST_FETCH:  if (!bus.waitrequest) state_d = ST_DECODE;
      ST_DECODE: state_d = ST_EXEC1;
      default: begin
        if (!stall_c) begin
          if (!is_last)
            state_d = state_t'(3'(state_q) + 3'd1);
          else if (delay_q && halt_pend_q)
            state_d = ST_HALTED;
          else
            state_d = ST_FETCH;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_FETCH;
      cnt_q       <= 3'd0;
      redirect_q  <= 1'b0;
      halt_pend_q <= 1'b0;
      delay_q     <= 1'b0;
      count_q     <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_DECODE)
        cnt_q <= ec_clamped;
      if ((state_q == ST_FETCH) && !bus.waitrequest)
        redirect_q <= 1'b0;
      // Branches are only honoured outside a delay slot; the slot's retire closes it.
      if (retire_c) begin
        count_q <= count_q + 1'b1;
        if (delay_q) begin
          delay_q     <= 1'b0;
          halt_pend_q <= 1'b0;
        end else if (bus.branch_taken) begin
          redirect_q  <= 1'b1;
          delay_q     <= 1'b1;
          halt_pend_q <= bus.target_zero;
        end
      end
    end
  end

  assign bus.state         = 3'(state_q);
  assign bus.exec_last     = is_last;
  assign bus.stall         = stall_c;
  assign bus.active        = (state_q != ST_HALTED);
  assign bus.pc_use_target = (state_q == ST_FETCH) && redirect_q;
  assign bus.in_delay_slot = delay_q;
  assign bus.retire        = retire_c;
  assign bus.instr_count   = count_q;
endmodule

// File: tb/tb_mips_cpu_sequencer.sv
// tb/tb_mips_cpu_sequencer.sv - directed and randomized instruction-level checks
// of mips_cpu_sequencer against an instruction-timing model
module tb_mips_cpu_sequencer;
  localparam int EXEC_STATES = 3;
  localparam int COUNT_W     = 32;

  logic clk = 1'b0;
  logic reset = 1'b1;

  mips_cpu_sequencer_if #(.COUNT_W(COUNT_W)) bus ();

  mips_cpu_sequencer #(.EXEC_STATES(EXEC_STATES), .COUNT_W(COUNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Instruction-level model: retired count and branch/delay-slot bookkeeping.
  int m_count;
  bit m_redirect, m_delay, m_halt, m_halted;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input int st, input bit stl, input bit last, input bit ret);
    chk({tag, " state"},         32'(bus.state), st);
    chk({tag, " stall"},         32'(bus.stall), 32'(stl));
    chk({tag, " exec_last"},     32'(bus.exec_last), 32'(last));
    chk({tag, " retire"},        32'(bus.retire), 32'(ret));
    chk({tag, " active"},        32'(bus.active), 32'(st != 0));
    chk({tag, " pc_use_target"}, 32'(bus.pc_use_target), 32'((st == 1) && m_redirect));
    chk({tag, " in_delay_slot"}, 32'(bus.in_delay_slot), 32'(m_delay));
    chk({tag, " instr_count"},   bus.instr_count, m_count);
  endtask

  task automatic noise();
    bus.exec_cycles  = 3'($urandom);
    bus.mem_access   = 1'($urandom);
    bus.waitrequest  = 1'($urandom);
    bus.muldiv_wait  = 1'($urandom);
    bus.muldiv_busy  = 1'($urandom);
    bus.branch_taken = 1'($urandom);
    bus.target_zero  = 1'($urandom);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.exec_cycles = 3'd0; bus.mem_access = 1'b0; bus.waitrequest = 1'b0;
    bus.muldiv_wait = 1'b0; bus.muldiv_busy = 1'b0;
    bus.branch_taken = 1'b0; bus.target_zero = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    m_count = 0; m_redirect = 0; m_delay = 0; m_halt = 0; m_halted = 0;
    #1 chk_outs("reset", 1, 0, 0, 0);
  endtask

  // One instruction: FETCH (fw wait cycles), DECODE, then N = clamp(ec) EXEC states,
  // with sn stall cycles in EXEC sk (or random stalls when rnd is set).
  task automatic run_instr(input int ec, input int fw, input int sk, input int sn,
                           input bit rnd, input bit br, input bit tz);
    int n, nfw, ns;
    bit stalled;
    n   = (ec == 0) ? 1 : ((ec > EXEC_STATES) ? EXEC_STATES : ec);
    nfw = rnd ? $urandom_range(0, 2) : fw;
    for (int i = 0; i <= nfw; i++) begin
      noise();
      bus.waitrequest = (i < nfw);
      #1 chk_outs("fetch", 1, i < nfw, 0, 0);
      @(negedge clk);
    end
    m_redirect = 0;
    noise();
    bus.exec_cycles = 3'(ec);
    #1 chk_outs("decode", 2, 0, 0, 0);
    @(negedge clk);
    for (int k = 1; k <= n; k++) begin
      if (rnd) ns = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0;
      else     ns = (k == sk) ? sn : 0;
      for (int j = 0; j <= ns; j++) begin
        noise();
        stalled = (j < ns);
        if (stalled) begin
          if ($urandom_range(0, 1) == 1) begin
            bus.mem_access = 1'b1; bus.waitrequest = 1'b1;
          end else begin
            bus.muldiv_wait = 1'b1; bus.muldiv_busy = 1'b1;
          end
        end else begin
          if (bus.mem_access)  bus.waitrequest = 1'b0;
          if (bus.muldiv_wait) bus.muldiv_busy = 1'b0;
          if (k == n) begin
            bus.branch_taken = br;
            bus.target_zero  = tz;
          end
        end
        #1 chk_outs("exec", 2 + k, stalled, k == n, (k == n) && !stalled);
        @(negedge clk);
      end
    end
    m_count++;
    if (m_delay) begin
      m_delay  = 0;
      m_halted = m_halt;
      m_halt   = 0;
    end else if (br) begin
      m_redirect = 1;
      m_delay    = 1;
      m_halt     = tz;
    end
  endtask

  task automatic chk_halted(input int ncyc);
    for (int i = 0; i < ncyc; i++) begin
      noise();
      #1 chk_outs("halted", 0, 0, 0, 0);
      @(negedge clk);
    end
  endtask

  initial begin
    bit br, tz;
    do_reset();

    repeat (3) run_instr(1, 0, 0, 0, 0, 0, 0);
    #1 chk("addu x3 instr_count", bus.instr_count, 3);

    run_instr(1, 4, 0, 0, 0, 0, 0);
    run_instr(2, 0, 1, 2, 0, 0, 0);

    run_instr(1, 0, 0, 0, 0, 1, 0);
    run_instr(2, 2, 0, 0, 0, 0, 0);
    run_instr(1, 0, 0, 0, 0, 0, 0);

    run_instr(0, 0, 0, 0, 0, 0, 0);
    run_instr(7, 0, 3, 1, 0, 0, 0);

    run_instr(2, 0, 2, 1, 0, 1, 1);
    run_instr(3, 1, 0, 0, 0, 0, 0);
    chk_halted(20);

    do_reset();
    run_instr(1, 0, 0, 0, 0, 1, 0);
    repeat (2) begin
      noise();
      bus.waitrequest = 1'b1;
      #1 chk_outs("midstall", 1, 1, 0, 0);
      @(negedge clk);
    end
    do_reset();

    for (int it = 0; it < 300; it++) begin
      if (m_halted) begin
        chk_halted(3);
        do_reset();
      end
      br = ($urandom_range(0, 3) == 0);
      tz = br && ($urandom_range(0, 5) == 0);
      run_instr($urandom_range(0, 7), 0, 0, 0, 1, br, tz);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
